// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry and
// the soft-clear sequencer state encoding.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between issue/writeback (master) and the register file (slave).
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     clr_req;
  logic                     busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    input  rd_data, rd_pending, busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
    output rd_data, rd_pending, busy
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Soft-clear sequencer: walks an index over every entry, one per cycle,
// and holds busy high for the whole sweep.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // Last entry is the all-ones index, so the sweep ends when idx saturates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (&idx_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o    = (state_q == ST_CLEAR);
  assign clr_we_o  = (state_q == ST_CLEAR);
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero register, write bypass,
// per-entry pending scoreboard and a sequenced soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;

  logic              busy;
  logic              clrWe;
  logic [ADDR_W-1:0] clrIdx;
  logic              wrAccept;
  logic              rsvAccept;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_req_i (bus.clr_req),
    .busy_o    (busy),
    .clr_we_o  (clrWe),
    .clr_idx_o (clrIdx)
  );

  assign wrAccept  = bus.wr_en && !busy && !(ZERO_REG && (bus.wr_addr == '0));
  assign rsvAccept = bus.rsv_en && !busy && !(ZERO_REG && (bus.rsv_addr == '0));

  // Reserve is applied after the write so a new producer keeps the entry pending.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    if (clrWe) begin
      mem_d[clrIdx]     = '0;
      pending_d[clrIdx] = 1'b0;
    end else begin
      if (wrAccept) begin
        mem_d[bus.wr_addr]     = bus.wr_data;
        pending_d[bus.wr_addr] = 1'b0;
      end
      if (rsvAccept) begin
        pending_d[bus.rsv_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdPend;
  logic [ADDR_W-1:0]        rdAddr;

  // Zero register outranks bypass so a dropped write to entry 0 never leaks.
  always_comb begin
    rdData = '0;
    rdPend = '0;
    rdAddr = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdAddr = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (busy) begin
        rdData[p*DATA_W +: DATA_W] = '0;
        rdPend[p]                  = 1'b0;
      end else if (ZERO_REG && (rdAddr == '0)) begin
        rdData[p*DATA_W +: DATA_W] = '0;
        rdPend[p]                  = 1'b0;
      end else if (BYPASS && bus.wr_en && (bus.wr_addr == rdAddr)) begin
        rdData[p*DATA_W +: DATA_W] = bus.wr_data;
        rdPend[p]                  = 1'b0;
      end else begin
        rdData[p*DATA_W +: DATA_W] = mem_q[rdAddr];
        rdPend[p]                  = pending_q[rdAddr];
      end
    end
  end

  assign bus.rd_data    = rdData;
  assign bus.rd_pending = rdPend;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default geometry
// (32-bit data, 32 entries, two read ports, zero register and bypass on).
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_mp_if #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) bus ();

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (1'b1),
    .BYPASS   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past a rising edge and settle so inputs change away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    bus.rd_addr = {5'd3, 5'd3};
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy);
    end
    checks++;
    if (bus.rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_rd_data: got %h expected 0", bus.rd_data);
    end
    checks++;
    if (bus.rd_pending !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_rd_pending: got %b expected 00", bus.rd_pending);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reserve_bypass();
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd5;
    tick();
    bus.rsv_en  = 1'b0;
    bus.rd_addr = {5'd6, 5'd5};
    #1;
    checks++;
    if (bus.rd_pending !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rsv_pending: got %b expected 01", bus.rd_pending);
    end
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL bypass_data: got %h expected deadbeef", bus.rd_data[31:0]);
    end
    checks++;
    if (bus.rd_pending[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_pending: got %b expected 0", bus.rd_pending[0]);
    end
    checks++;
    if (bus.rd_data[63:32] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL bypass_other_port: got %h expected 0", bus.rd_data[63:32]);
    end
    tick();
    bus.wr_en   = 1'b0;
    bus.rd_addr = {5'd5, 5'd6};
    #1;
    checks++;
    if (bus.rd_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL array_data_port1: got %h expected deadbeef", bus.rd_data[63:32]);
    end
    checks++;
    if (bus.rd_pending !== 2'b00) begin
      errors++;
      $display("[TB] FAIL array_pending: got %b expected 00", bus.rd_pending);
    end
  endtask

  task automatic test_zero_reg();
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 32'h123;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd0;
    bus.rd_addr  = {5'd0, 5'd0};
    #1;
    checks++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL zero_bypass: got %h expected 0", bus.rd_data[31:0]);
    end
    tick();
    bus.wr_en  = 1'b0;
    bus.rsv_en = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL zero_data: got %h expected 0", bus.rd_data);
    end
    checks++;
    if (bus.rd_pending !== 2'b00) begin
      errors++;
      $display("[TB] FAIL zero_pending: got %b expected 00", bus.rd_pending);
    end
  endtask

  task automatic test_write_reserve_same();
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 32'h55;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd7;
    bus.rd_addr  = {5'd0, 5'd7};
    tick();
    bus.wr_en  = 1'b0;
    bus.rsv_en = 1'b0;
    #1;
    checks++;
    if (bus.rd_data[31:0] !== 32'h55) begin
      errors++;
      $display("[TB] FAIL wr_rsv_data: got %h expected 55", bus.rd_data[31:0]);
    end
    checks++;
    if (bus.rd_pending[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wr_rsv_pending: got %b expected 1", bus.rd_pending[0]);
    end
  endtask

  task automatic test_soft_clear();
    logic [31:0] vals [4];
    int          cnt;
    vals[0] = 32'h100;
    vals[1] = 32'h200;
    vals[2] = 32'h594;
    vals[3] = 32'h410;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(i + 1);
      bus.wr_data = vals[i];
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.rd_addr = {5'd4, 5'd3};
    #1;
    checks++;
    if (bus.rd_data !== {32'h410, 32'h594}) begin
      errors++;
      $display("[TB] FAIL preclear_data: got %h expected 0000041000000594", bus.rd_data);
    end
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    bus.rd_addr = {5'd2, 5'd1};
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      if (cnt == 0) begin
        #1;
        checks++;
        if (bus.rd_data !== 64'h0) begin
          errors++;
          $display("[TB] FAIL busy_read_zero: got %h expected 0", bus.rd_data);
        end
      end
      if (cnt == 20) begin
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd9;
        bus.wr_data  = 32'hAAAA;
        bus.rsv_en   = 1'b1;
        bus.rsv_addr = 5'd10;
      end
      if (cnt == 21) begin
        bus.wr_en  = 1'b0;
        bus.rsv_en = 1'b0;
      end
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== 32) begin
      errors++;
      $display("[TB] FAIL clear_busy_cycles: got %0d expected 32", cnt);
    end
    for (int a = 1; a <= 4; a++) begin
      bus.rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (bus.rd_data !== 64'h0) begin
        errors++;
        $display("[TB] FAIL cleared_entry_%0d: got %h expected 0", a, bus.rd_data);
      end
    end
    bus.rd_addr = {5'd10, 5'd9};
    #1;
    checks++;
    if (bus.rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("[TB] FAIL busy_write_dropped: got %h expected 0", bus.rd_data[31:0]);
    end
    checks++;
    if (bus.rd_pending[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_reserve_dropped: got %b expected 0", bus.rd_pending[1]);
    end
    bus.rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (bus.rd_pending !== 2'b00) begin
      errors++;
      $display("[TB] FAIL cleared_pending_7: got %b expected 00", bus.rd_pending);
    end
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 32'h77;
    tick();
    bus.wr_en   = 1'b0;
    bus.rd_addr = {5'd0, 5'd2};
    #1;
    checks++;
    if (bus.rd_data[31:0] !== 32'h77) begin
      errors++;
      $display("[TB] FAIL first_write_after_clear: got %h expected 77", bus.rd_data[31:0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd12;
    bus.wr_data = 32'hABC;
    tick();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_clear_busy: got %0b expected 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear_busy: got %0b expected 0", bus.busy);
    end
    bus.rd_addr = {5'd2, 5'd12};
    #1;
    checks++;
    if (bus.rd_data !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear_data: got %h expected 0", bus.rd_data);
    end
    reset       = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd8;
    bus.wr_data = 32'h1;
    tick();
    bus.wr_en   = 1'b0;
    bus.rd_addr = {5'd8, 5'd12};
    #1;
    checks++;
    if (bus.rd_data !== {32'h1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL write_after_reset: got %h expected 0000000100000000", bus.rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idleInputs();
    $display("[TB] starting regfile_mp directed tests");
    test_reset();
    test_reserve_bypass();
    test_zero_reg();
    test_write_reserve_same();
    test_soft_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the datapath: next generation of the single-write, two-read CPU register file. Adds configurable width, depth and read-port count, optional hardwired zero register, write-to-read bypass, a per-register pending (scoreboard) bit for the issue stage, and a sequenced soft-clear that zeroes the array one entry per cycle. Sits between decode/issue (read, reserve) and writeback (write).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/reserves
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears array, pending bits, sequencer
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, port p at [p*DATA_W +: DATA_W]
- rd_pending  out  NUM_RD  pending bit for each read address, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve strobe: mark rsv_addr as awaiting a result
- rsv_addr  in  ADDR_W  reserve address
- clr_req  in  1  start soft clear (single-cycle pulse or level)
- busy  out  1  high while soft clear is in progress

## Operation
- Storage: DEPTH x DATA_W array plus DEPTH-bit pending vector.
- Write: on clk edge with wr_en=1 and not busy, array[wr_addr] <= wr_data, pending[wr_addr] <= 0. Dropped if ZERO_REG and wr_addr=0.
- Reserve: on clk edge with rsv_en=1 and not busy, pending[rsv_addr] <= 1. Dropped if ZERO_REG and rsv_addr=0.
- Write and reserve to same address in same cycle: array takes wr_data, pending ends 1 (new producer wins).
- Read port p: if busy -> rd_data=0, rd_pending=0. Else if ZERO_REG and addr=0 -> 0, pending 0. Else if BYPASS and wr_en and wr_addr=addr -> wr_data, pending 0. Else array[addr], pending[addr].
- Soft clear FSM, two states:
  - IDLE: busy=0; clr_req=1 -> CLEAR, idx <= 0.
  - CLEAR: busy=1; each cycle array[idx] <= 0, pending[idx] <= 0, idx <= idx+1; at idx=DEPTH-1 -> IDLE. clr_req ignored in CLEAR.
- All writes and reserves presented while busy=1 are discarded (not queued).

## Timing
- Reset (async): every array entry 0, pending all 0, state IDLE, idx 0; outputs: busy=0, rd_data=0, rd_pending=0 for all ports.
- Read latency 0 (combinational from rd_addr/array/bypass); write visible in array on the cycle after the edge, visible same cycle via bypass.
- Soft clear: busy rises the cycle after the edge sampling clr_req, stays high exactly DEPTH cycles; first write accepted on the edge where busy=0 again.
- Reset asserted mid-clear: immediate return to IDLE, array fully zero.
- idx is ADDR_W bits and wraps naturally; no out-of-range address exists.

## Structure
- Package regfile_pkg: FSM state encoding (ST_IDLE, ST_CLEAR), default parameter constants.
- Sub-module regfile_clear_seq: FSM + idx counter, outputs busy, clr_we, clr_idx; top instantiates one and generates NUM_RD read muxes.

## Test plan
- Reset then read all ports addr 3 -> rd_data 0, rd_pending 0, busy 0.
- rsv 5; next cycle rd_addr 5 -> pending 1; write 5 = 0xDEADBEEF -> same cycle read shows 0xDEADBEEF, pending 0 (bypass); next cycle array holds it.
- ZERO_REG=1: write 0 = 0x123, rsv 0 -> read 0 gives 0, pending 0.
- Write and reserve addr 7 same cycle with data 0x55 -> read 7 = 0x55, pending 1.
- clr_req with regs 1..4 = 0x100,0x200,0x594,0x410 -> busy high 32 cycles, writes during busy dropped, afterwards all reads 0.
- Assert reset at cycle 10 of a clear -> busy 0 immediately, all entries 0, subsequent write 8 = 1 reads back 1.
